pico_native_mem: RTL and testbench
==================================

PICO_NATIVE_MEM -- requirements
Module: pico_native_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, 256, RAM depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_STATES, 0, extra response cycles per access (0..15).
REQ-003 SHALL have parameter IO_BASE, 32'h1000_0000, base byte address of the I/O window (16-byte aligned).
REQ-004 SHALL have port clk, in, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, in, 1, synchronous active-low reset.
REQ-006 SHALL have port mem_valid, in, 1, request pending; the requester holds it until mem_ready.
REQ-007 SHALL have port mem_instr, in, 1, instruction fetch qualifier; no functional effect.
REQ-008 SHALL have port mem_addr, in, 32, byte address; bits [1:0] are ignored.
REQ-009 SHALL have port mem_wdata, in, 32, write data.
REQ-010 SHALL have port mem_wstrb, in, 4, byte-lane write enables; 0 means read.
REQ-011 SHALL have port mem_ready, out, 1, one-cycle registered completion pulse.
REQ-012 SHALL have port mem_rdata, out, 32, registered read data, valid while mem_ready=1.
REQ-013 SHALL have port gpio_out, out, 32, registered I/O output register.
REQ-014 SHALL have port bus_err, out, 1, sticky flag set by any unmapped access.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, with state and outputs registered.
REQ-016 In IDLE, with mem_valid=1 and mem_ready=0 at an edge, SHALL latch addr, wdata and wstrb, then go to WAIT if WAIT_STATES>0, else RESP.
REQ-017 WAIT SHALL count WAIT_STATES cycles, then go to RESP; mem_ready SHALL be high for exactly the one cycle spent in RESP.
REQ-018 Latency: request sampled at edge N -> mem_ready high in the cycle after edge N+WAIT_STATES.
REQ-019 RAM hit, defined as addr < MEM_WORDS*4: write updates only the strobed lanes of word addr[log2(MEM_WORDS)+1:2]; read returns the full word.
REQ-020 Write commit and mem_rdata load SHALL occur on the edge that raises mem_ready, using only the latched request.
REQ-021 A write returns mem_rdata equal to the pre-write word value.
REQ-022 I/O window, IO_BASE+0: R/W gpio_out with per-lane wstrb.
REQ-023 I/O window, IO_BASE+4: read-only cycle counter (see REQ-031); writes are ignored.
REQ-024 I/O window, IO_BASE+8 and IO_BASE+C: reads return 0; writes are ignored.
REQ-025 Any other address SHALL still complete with the normal latency, return mem_rdata=0, perform no write, and set bus_err.
REQ-026 If mem_valid drops while in WAIT, SHALL abort to IDLE with no write and no mem_ready pulse.
REQ-027 A new request SHALL NOT be accepted in the cycle mem_ready is high; back-to-back throughput is one access per WAIT_STATES+2 cycles.

Reset
REQ-028 While resetn=0 at an edge, the block SHALL force: state=IDLE, mem_ready=0, mem_rdata=0, gpio_out=0, bus_err=0, wait counter=0, cycle counter=0.
REQ-029 Reset mid-access SHALL discard the latched request with no RAM write; RAM contents SHALL NOT be cleared by reset.
REQ-030 The first request SHALL be accepted no earlier than the first edge with resetn=1.

Configuration
REQ-031 With macro PICO_MEM_CYCLE_CNT_EN defined, a 32-bit counter SHALL increment every non-reset cycle, wrap from 0xFFFFFFFF to 0, and be readable at IO_BASE+4.
REQ-032 With PICO_MEM_CYCLE_CNT_EN undefined, the counter SHALL be absent and IO_BASE+4 SHALL read 0, still mapped, with no bus_err.

Verification
REQ-033 Reset: hold resetn=0 for 3 cycles with mem_valid=1 -> mem_ready, gpio_out and bus_err all 0, and no write occurs.
REQ-034 WAIT_STATES=0, word 2 preloaded 0x0000a103, read addr 0x8 -> mem_ready one cycle after the sampling edge, mem_rdata=0x0000a103, pulse width 1.
REQ-035 Word 255 preloaded 0, write addr 0x3fc wdata 0xdeadbeef wstrb 4'b0101, then read -> 0x00ad00ef.
REQ-036 WAIT_STATES=3, read addr 0x0 -> mem_ready 4 cycles after the sampling edge; mem_valid dropped in WAIT -> no pulse, state returns to IDLE.
REQ-037 Write IO_BASE 0x12345678 wstrb 4'b1111 -> gpio_out=0x12345678; read addr 0x400 with MEM_WORDS=256 -> mem_rdata=0 and bus_err=1, still 1 after a following valid access.
REQ-038 With PICO_MEM_CYCLE_CNT_EN, two reads of IO_BASE+4 issued 10 cycles apart -> values differ by 10; without the macro, both reads return 0.

Source files
------------

// File: rtl/pico_native_mem.sv
// pico_native_mem
// ----------------
// Memory slave for the PicoRV32 native interface: a word-addressed RAM
// with byte-lane writes, a small I/O window and a sticky bus-error flag.
// Every access runs IDLE -> (WAIT) -> RESP -> IDLE and signals completion
// with a single registered mem_ready pulse.
//
// Parameters
//   MEM_WORDS   RAM depth in 32-bit words (power of two, 16..65536)
//   WAIT_STATES extra response cycles per access (0..15)
//   IO_BASE     byte address of the 16-byte I/O window
//
// Ports
//   clk        sole clock, rising edge
//   resetn     synchronous active-low reset
//   mem_valid  request pending, held until mem_ready
//   mem_instr  fetch qualifier, no functional effect
//   mem_addr   byte address, bits [1:0] ignored
//   mem_wdata  write data
//   mem_wstrb  byte-lane write enables, 0 = read
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid while mem_ready=1
//   gpio_out   I/O output register (IO_BASE+0)
//   bus_err    sticky, set by any unmapped access
//
// I/O map: +0 gpio_out (R/W), +4 cycle counter (RO), +8/+C read as 0.
//
// Optional feature: define PICO_MEM_CYCLE_CNT_EN to build the free-running
// 32-bit cycle counter at IO_BASE+4. Without it that address reads 0.

module pico_native_mem #(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] IO_BASE     = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] gpio_out,
    output logic        bus_err
);

    localparam int AW          = $clog2(MEM_WORDS);
    localparam int WAIT_LAST_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        latch_req;
    logic        access;

    logic [31:0] ram [MEM_WORDS];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. 'access' marks the edge that enters RESP: the RAM
    // write and the read-data load both happen on that edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        latch_req     = 1'b0;
        access        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // mem_ready is only high in RESP, so the guard below keeps
                // the completing cycle from being taken as a new request.
                if (mem_valid && !mem_ready) begin
                    latch_req = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next    = S_WAIT;
                        wait_cnt_next = 4'd0;
                    end else begin
                        state_next = S_RESP;
                        access     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    // Requester withdrew: abandon without side effects.
                    state_next    = S_IDLE;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next    = S_RESP;
                    wait_cnt_next = 4'd0;
                    access        = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next    = S_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request used by the access. With no wait states the access happens
    // on the same edge that latches the request, so the live bus values
    // (the ones being latched) are used; otherwise the latched copy.
    // ------------------------------------------------------------------
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_wstrb;

    assign acc_addr  = (state_reg == S_IDLE) ? mem_addr  : addr_reg;
    assign acc_wdata = (state_reg == S_IDLE) ? mem_wdata : wdata_reg;
    assign acc_wstrb = (state_reg == S_IDLE) ? mem_wstrb : wstrb_reg;

    // Address decode. RAM hit is addr < MEM_WORDS*4, i.e. all bits above
    // the word index are zero.
    logic          ram_hit, io_hit;
    logic [1:0]    io_sel;
    logic [AW-1:0] ram_idx;

    assign ram_hit = (acc_addr[31:AW+2] == '0);
    assign io_hit  = !ram_hit && (acc_addr[31:4] == IO_BASE[31:4]);
    assign io_sel  = acc_addr[3:2];
    assign ram_idx = acc_addr[AW+1:2];

    // Byte-lane merge of write data into the current RAM word / gpio value.
    logic [31:0] ram_word, ram_merged, gpio_merged;

    assign ram_word = ram[ram_idx];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_merged[gi*8 +: 8]  = acc_wstrb[gi] ? acc_wdata[gi*8 +: 8]
                                                          : ram_word[gi*8 +: 8];
            assign gpio_merged[gi*8 +: 8] = acc_wstrb[gi] ? acc_wdata[gi*8 +: 8]
                                                          : gpio_out[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_val;

`ifdef PICO_MEM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_cnt_reg <= 32'd0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end

    assign cycle_val = cycle_cnt_reg;
`else
    assign cycle_val = 32'd0;
`endif

    // Read data for the current access (pre-write value on writes).
    logic [31:0] rdata_next;

    always_comb begin
        rdata_next = 32'd0;
        if (ram_hit) begin
            rdata_next = ram_word;
        end else if (io_hit) begin
            case (io_sel)
                2'd0:    rdata_next = gpio_out;
                2'd1:    rdata_next = cycle_val;
                default: rdata_next = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM write port. No reset so the array maps to block RAM; resetn
    // gates the write so a reset edge never commits a request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetn && access && ram_hit && (acc_wstrb != 4'd0)) begin
            ram[ram_idx] <= ram_merged;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and latched request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            gpio_out  <= 32'd0;
            bus_err   <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            wstrb_reg <= 4'd0;
        end else begin
            mem_ready <= access;
            if (latch_req) begin
                addr_reg  <= mem_addr;
                wdata_reg <= mem_wdata;
                wstrb_reg <= mem_wstrb;
            end
            if (access) begin
                mem_rdata <= rdata_next;
                if (io_hit && (io_sel == 2'd0)) begin
                    gpio_out <= gpio_merged;
                end
                if (!ram_hit && !io_hit) begin
                    bus_err <= 1'b1;
                end
            end
        end
    end

    // Inputs that carry no function here.
    logic unused_bits;
    assign unused_bits = ^{mem_instr, acc_addr[1:0]};

endmodule

// File: tb/tb_pico_native_mem.sv
// Testbench for pico_native_mem. Two instances share clock and reset:
// dut0 with no wait states, dut1 with three. A behavioural model (word
// array, gpio value, sticky error flag) predicts every response.
module tb_pico_native_mem;

    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] IO_BASE   = 32'h1000_0000;
`ifdef PICO_MEM_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        ready [2];
    logic [31:0] rdata [2];
    logic [31:0] gpio  [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ram  [2][MEM_WORDS];
    logic [31:0] m_gpio [2];
    bit          m_err  [2];

    always #5 clk = ~clk;

    pico_native_mem #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(0), .IO_BASE(IO_BASE)) dut0 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_instr(1'b0),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .gpio_out(gpio[0]), .bus_err(err[0])
    );

    pico_native_mem #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(3), .IO_BASE(IO_BASE)) dut1 (
        .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_instr(1'b1),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .gpio_out(gpio[1]), .bus_err(err[1])
    );

    function automatic int ws_of(input int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    // Behavioural model of one access: returns the expected rdata and
    // whether that value is defined for this access.
    function automatic logic [31:0] model_access(input int sel, input logic [31:0] a,
                                                 input logic [31:0] d, input logic [3:0] s,
                                                 output bit chk);
        logic [31:0] old;
        int idx;
        old = 32'd0;
        chk = 1'b1;
        if (a < 32'(MEM_WORDS * 4)) begin
            idx = int'(a >> 2);
            old = m_ram[sel][idx];
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_ram[sel][idx][b*8 +: 8] = d[b*8 +: 8];
            end
        end else if ((a >> 4) == (IO_BASE >> 4)) begin
            case (a[3:2])
                2'd0: begin
                    old = m_gpio[sel];
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) m_gpio[sel][b*8 +: 8] = d[b*8 +: 8];
                    end
                    chk = (s == 4'd0);
                end
                2'd1:    chk = (s == 4'd0) && !CNT_EN;
                default: chk = (s == 4'd0);
            endcase
        end else begin
            m_err[sel] = 1'b1;
        end
        return old;
    endfunction

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and wait for its mem_ready (bounded).
    // lat counts rising edges from raising mem_valid to seeing mem_ready.
    task automatic bus_access(input int sel, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] rd, output int lat);
        int n;
        n   = 0;
        rd  = 32'd0;
        lat = -1;
        valid[sel] = 1'b1;
        addr[sel]  = a;
        wdata[sel] = d;
        wstrb[sel] = s;
        while (n < 40 && lat < 0) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[sel]) begin
                rd  = rdata[sel];
                lat = n;
            end
        end
        valid[sel] = 1'b0;
        wstrb[sel] = 4'd0;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL timeout dut%0d addr=%h: mem_ready not seen in 40 cycles", sel, a);
        end
        $display("txn dut%0d addr=%h wdata=%h wstrb=%b rdata=%h lat=%0d", sel, a, d, s, rd, lat);
    endtask

    // Access plus model comparison of rdata, gpio_out and bus_err.
    task automatic checked_access(input int sel, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, output int lat);
        logic [31:0] rd, exp;
        bit chk;
        exp = model_access(sel, a, d, s, chk);
        bus_access(sel, a, d, s, rd, lat);
        if (chk) begin
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL rdata dut%0d addr=%h: got %h expected %h", sel, a, rd, exp);
            end
        end
        checks++;
        if (gpio[sel] !== m_gpio[sel] || err[sel] !== m_err[sel]) begin
            errors++;
            $display("FAIL state dut%0d: gpio %h/err %b expected %h/%b",
                     sel, gpio[sel], err[sel], m_gpio[sel], m_err[sel]);
        end
    endtask

    // Reset with a request held: outputs stay 0 throughout.
    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b1; addr[i] = 32'h40; wdata[i] = 32'h1111_2222; wstrb[i] = 4'hF;
        end
        for (int c = 0; c < 3; c++) begin
            idle_cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ready[i] !== 1'b0 || gpio[i] !== 32'd0 || err[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset dut%0d cycle %0d: ready=%b gpio=%h err=%b required 0/0/0",
                             i, c, ready[i], gpio[i], err[i]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; wstrb[i] = 4'd0;
            m_gpio[i] = 32'd0; m_err[i] = 1'b0;
        end
        resetn = 1'b1;
        idle_cycle();
    endtask

    // Give every RAM word a known value.
    task automatic test_init();
        int lat;
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < MEM_WORDS; w++) begin
                checked_access(i, 32'(w * 4), $urandom, 4'hF, lat);
            end
        end
    endtask

    // Reset while requests are pending (dut1 mid-WAIT): no write, state cleared.
    task automatic test_reset_mid();
        int lat;
        for (int i = 0; i < 2; i++) begin
            checked_access(i, IO_BASE, 32'hA5A5_5A5A, 4'hF, lat);
            checked_access(i, 32'h0000_0800, 32'd0, 4'd0, lat);
        end
        idle_cycle();
        valid[1] = 1'b1; addr[1] = 32'h44; wdata[1] = 32'hBAD0_0001; wstrb[1] = 4'hF;
        idle_cycle();
        resetn = 1'b0;
        valid[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hBAD0_0000; wstrb[0] = 4'hF;
        repeat (3) begin
            idle_cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ready[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_ready dut%0d: got %b required 0", i, ready[i]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; wstrb[i] = 4'd0;
            m_gpio[i] = 32'd0; m_err[i] = 1'b0;
            checks++;
            if (gpio[i] !== 32'd0 || err[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_clear dut%0d: gpio=%h err=%b required 0/0", i, gpio[i], err[i]);
            end
        end
        resetn = 1'b1;
        idle_cycle();
        for (int i = 0; i < 2; i++) begin
            checked_access(i, 32'h40, 32'd0, 4'd0, lat);
            checked_access(i, 32'h44, 32'd0, 4'd0, lat);
        end
    endtask

    // Zero-wait read of a preloaded word: latency and pulse width.
    task automatic test_read_ws0();
        int lat;
        logic [31:0] rd;
        bit chk;
        checked_access(0, 32'h8, 32'h0000_a103, 4'hF, lat);
        idle_cycle();
        void'(model_access(0, 32'h8, 32'd0, 4'd0, chk));
        bus_access(0, 32'h8, 32'd0, 4'd0, rd, lat);
        checks++;
        if (rd !== 32'h0000_a103 || lat !== 1) begin
            errors++;
            $display("FAIL read_ws0: rdata=%h lat=%0d required 0000a103 lat=1", rd, lat);
        end
        idle_cycle();
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL pulse_ws0: ready=%b one cycle later, required 0", ready[0]);
        end
        // Address bits [1:0] do not select anything.
        checked_access(0, 32'hB, 32'd0, 4'd0, lat);
    endtask

    // Partial-lane write to the last word; write returns the old word.
    task automatic test_strobe();
        int lat;
        logic [31:0] rd;
        bit chk;
        checked_access(0, 32'h3fc, 32'd0, 4'hF, lat);
        checked_access(0, 32'h3fc, 32'hdead_beef, 4'b0101, lat);
        void'(model_access(0, 32'h3fc, 32'd0, 4'd0, chk));
        bus_access(0, 32'h3fc, 32'd0, 4'd0, rd, lat);
        checks++;
        if (rd !== 32'h00ad_00ef) begin
            errors++;
            $display("FAIL strobe: rdata=%h required 00ad00ef", rd);
        end
    endtask

    // Three wait states: latency, pulse width, abort in WAIT.
    task automatic test_wait_abort();
        int lat;
        bit saw;
        idle_cycle();
        checked_access(1, 32'h0, 32'd0, 4'd0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL latency_ws3: got %0d required 4", lat);
        end
        idle_cycle();
        checks++;
        if (ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL pulse_ws3: ready=%b one cycle later, required 0", ready[1]);
        end
        valid[1] = 1'b1; addr[1] = 32'h0; wdata[1] = 32'hFFFF_0000; wstrb[1] = 4'hF;
        idle_cycle();
        idle_cycle();
        valid[1] = 1'b0; wstrb[1] = 4'd0;
        saw = 1'b0;
        repeat (8) begin
            idle_cycle();
            if (ready[1]) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: mem_ready seen after abort, required none");
        end
        checked_access(1, 32'h0, 32'd0, 4'd0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL abort_idle: next latency %0d required 4", lat);
        end
    endtask

    // I/O window and unmapped accesses.
    task automatic test_io();
        int lat;
        checked_access(0, IO_BASE, 32'h1234_5678, 4'hF, lat);
        checks++;
        if (gpio[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL gpio_write: got %h required 12345678", gpio[0]);
        end
        checked_access(0, IO_BASE, 32'h0000_ab00, 4'b0010, lat);
        checked_access(0, IO_BASE, 32'd0, 4'd0, lat);
        checked_access(0, IO_BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, lat);
        checked_access(0, IO_BASE + 32'h8, 32'd0, 4'd0, lat);
        checked_access(0, IO_BASE + 32'hC, 32'd0, 4'd0, lat);
        checked_access(0, IO_BASE + 32'h4, 32'h5555_5555, 4'hF, lat);
        checked_access(0, 32'h400, 32'd0, 4'd0, lat);
        checks++;
        if (err[0] !== 1'b1) begin
            errors++;
            $display("FAIL bus_err_set: got %b required 1", err[0]);
        end
        checked_access(0, 32'h8, 32'd0, 4'd0, lat);
        checks++;
        if (err[0] !== 1'b1) begin
            errors++;
            $display("FAIL bus_err_sticky: got %b required 1", err[0]);
        end
    endtask

    // Two counter reads sampled 10 edges apart.
    task automatic test_cycle_cnt();
        int lat;
        logic [31:0] v1, v2;
        idle_cycle();
        bus_access(0, IO_BASE + 32'h4, 32'd0, 4'd0, v1, lat);
        repeat (9) @(posedge clk);
        #1;
        bus_access(0, IO_BASE + 32'h4, 32'd0, 4'd0, v2, lat);
        checks++;
        if (CNT_EN) begin
            if (v2 - v1 !== 32'd10) begin
                errors++;
                $display("FAIL cycle_cnt: v1=%h v2=%h diff %0d required 10", v1, v2, v2 - v1);
            end
        end else begin
            if (v1 !== 32'd0 || v2 !== 32'd0) begin
                errors++;
                $display("FAIL cycle_cnt_off: v1=%h v2=%h required 0/0", v1, v2);
            end
        end
    endtask

    // Throughput: one access per WAIT_STATES+2 cycles.
    task automatic test_back_to_back();
        int lat;
        for (int i = 0; i < 2; i++) begin
            idle_cycle();
            for (int k = 0; k < 4; k++) begin
                checked_access(i, 32'(k * 4 + 32'h100), 32'(k) ^ $urandom, 4'hF, lat);
                checks++;
                if (lat !== ((k == 0) ? ws_of(i) + 1 : ws_of(i) + 2)) begin
                    errors++;
                    $display("FAIL b2b dut%0d #%0d: latency %0d required %0d", i, k, lat,
                             (k == 0) ? ws_of(i) + 1 : ws_of(i) + 2);
                end
            end
        end
    endtask

    // Random mix of RAM, I/O and unmapped accesses.
    task automatic test_random();
        int lat;
        int kind;
        logic [31:0] a;
        logic [3:0] s;
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 60; t++) begin
                kind = int'($urandom_range(0, 9));
                if (kind < 6) a = ($urandom_range(0, MEM_WORDS - 1) << 2) | $urandom_range(0, 3);
                else if (kind < 9) a = IO_BASE | ($urandom_range(0, 3) << 2);
                else a = 32'h2000_0000 + ($urandom_range(0, 1023) << 2);
                s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                checked_access(i, a, $urandom, s, lat);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; wstrb[i] = 4'd0;
        end
        resetn = 1'b0;
        #1;
        test_reset();
        test_init();
        test_reset_mid();
        test_read_ws0();
        test_strobe();
        test_wait_abort();
        test_io();
        test_cycle_cnt();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
